// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
//   imem_arb_state_t : sequencer state encoding
//   BYTES_PER_WORD   : bytes assembled into one response word
//   BEAT_W           : width of the byte-beat counter
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } imem_arb_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BEAT_W         = 2;

endpackage

// File: rtl/imem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   valid[1:0] : request valids, bit N = port N
//   update     : record the current grant as the last winner
//   grant[1:0] : one-hot grant (zero when no valid)
//   grant_idx  : index of the granted port
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       update,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // Starts at 1 so port 0 wins the first tie after reset.
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign grant_idx = grant[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (update && (grant != 2'b00)) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one byte-wide instruction memory between fetch (port 0) and
// data/debug (port 1). Each accepted request reads 4 consecutive bytes
// and returns them big-endian as one 32-bit word.
//   clk, rst_n                     : clock, synchronous active-low reset
//   reqN_valid/addr/ready          : request channel, port N
//   rspN_valid/ready/data/err      : response channel, port N
//   mem_req, mem_addr, mem_rdata   : byte read port, rdata combinational
//
// state | meaning
// IDLE  | arbitrate, accept one request
// READ  | four byte beats from the memory
// RESP  | word presented to the owner until it handshakes
module imem_arbiter import imem_pkg::*; #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [31:0]           req0_addr,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [31:0]           rsp0_data,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  input  logic [31:0]           req1_addr,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [31:0]           rsp1_data,
  output logic                  rsp1_err,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  imem_arb_state_t       state, next_state;
  logic [1:0]            grant;
  logic                  grant_idx;
  logic                  accept;
  logic [31:0]           sel_addr;
  logic                  oor;
  logic [BEAT_W-1:0]     beat;
  logic [31:0]           word;
  logic                  owner;
  logic [ADDR_WIDTH-1:0] base;
  logic                  err;
  logic [ADDR_WIDTH-1:0] rd_addr;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     ({req1_valid, req0_valid}),
    .update    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_addr = grant_idx ? req1_addr : req0_addr;
  // Any address bit above the memory's range makes the request an error.
  assign oor      = (sel_addr >> ADDR_WIDTH) != 32'd0;
  // Modulo add: a read starting near the top wraps to address 0.
  assign rd_addr  = base + ADDR_WIDTH'(beat);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        // Gated by rst_n so no request looks accepted while reset is held.
        if (rst_n && (grant != 2'b00)) begin
          accept     = 1'b1;
          req0_ready = grant[0];
          req1_ready = grant[1];
          next_state = oor ? RESP : READ;
        end
      end
      READ: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr;
        if (beat == BEAT_W'(BYTES_PER_WORD - 1)) next_state = RESP;
      end
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        if (owner ? rsp1_ready : rsp0_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat  <= '0;
      word  <= '0;
      owner <= 1'b0;
      base  <= '0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        owner <= grant_idx;
        base  <= sel_addr[ADDR_WIDTH-1:0];
        beat  <= '0;
        err   <= oor;
        if (oor) word <= '0;
      end
      if (state == READ) begin
        // First byte read lands in the most significant byte.
        case (beat)
          2'd0: word[31:24] <= mem_rdata;
          2'd1: word[23:16] <= mem_rdata;
          2'd2: word[15:8]  <= mem_rdata;
          2'd3: word[7:0]   <= mem_rdata;
          default: ;
        endcase
        beat <= beat + 1'b1;
      end
    end
  end

  // Both ports see the shared word; it only matters to the owner while valid.
  assign rsp0_data = word;
  assign rsp1_data = word;
  assign rsp0_err  = err;
  assign rsp1_err  = err;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
  logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0]   req0_addr, req1_addr, rsp0_data, rsp1_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [7:0]    mem [128];

  assign mem_rdata = mem[mem_addr];

  imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp0_err   (rsp0_err),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .rsp1_err   (rsp1_err),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: a transaction is "age" cycles old; ages 1..4
  // are the byte reads, anything later is the response phase.
  bit          m_busy  = 1'b0;
  int          m_age   = 0;
  bit          m_owner = 1'b0;
  int          m_base  = 0;
  bit          m_err   = 1'b0;
  logic [31:0] m_word  = '0;
  bit          m_last  = 1'b1;

  function automatic logic [31:0] word_at(input int a);
    return {mem[a % 128], mem[(a + 1) % 128], mem[(a + 2) % 128], mem[(a + 3) % 128]};
  endfunction

  typedef struct {
    bit          owner;
    logic [31:0] data;
    bit          err;
    int          acc;
    int          vld;
    int          hs;
  } rsp_t;

  rsp_t log_q[$];
  int   maddr_q[$];
  int   cur_acc = 0;
  int   cur_vld = 0;
  bit   vld_seen = 1'b0;

  always @(negedge clk) begin : cmp
    bit          e_r0, e_r1, e_mr, e_v0, e_v1, g, any_v;
    int          e_ma;
    logic [31:0] a;
    if (cyc >= 1) begin
      e_r0 = 0; e_r1 = 0; e_mr = 0; e_v0 = 0; e_v1 = 0; e_ma = 0;
      any_v = req0_valid || req1_valid;
      g = (req0_valid && req1_valid) ? !m_last : req1_valid;
      if (!m_busy) begin
        if (rst_n && any_v) begin
          e_r0 = !g;
          e_r1 = g;
        end
      end else if (!m_err && m_age <= 4) begin
        e_mr = 1;
        e_ma = (m_base + m_age - 1) % 128;
      end else begin
        e_v0 = !m_owner;
        e_v1 = m_owner;
      end
      check("req0_ready", 32'(req0_ready), 32'(e_r0));
      check("req1_ready", 32'(req1_ready), 32'(e_r1));
      check("mem_req",    32'(mem_req),    32'(e_mr));
      check("mem_addr",   32'(mem_addr),   32'(e_ma));
      check("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
      check("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
      if (e_v0 || e_v1) begin
        check("rsp_data", e_v1 ? rsp1_data : rsp0_data, m_word);
        check("rsp_err",  32'(e_v1 ? rsp1_err : rsp0_err), 32'(m_err));
      end

      if (mem_req) maddr_q.push_back(int'(mem_addr));
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        cur_acc  = cyc;
        vld_seen = 0;
      end
      if ((rsp0_valid || rsp1_valid) && !vld_seen) begin
        vld_seen = 1;
        cur_vld  = cyc;
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))
        log_q.push_back('{rsp1_valid, rsp1_valid ? rsp1_data : rsp0_data,
                          rsp1_valid ? rsp1_err : rsp0_err, cur_acc, cur_vld, cyc});

      if (!rst_n) begin
        m_busy = 0;
        m_last = 1;
      end else if (!m_busy) begin
        if (any_v) begin
          a       = g ? req1_addr : req0_addr;
          m_owner = g;
          m_base  = int'(a % 128);
          m_err   = a >= 32'd128;
          m_word  = m_err ? 32'd0 : word_at(m_base);
          m_last  = g;
          m_busy  = 1;
          m_age   = m_err ? 5 : 1;
        end
      end else if (m_age <= 4) begin
        m_age++;
      end else if (m_owner ? rsp1_ready : rsp0_ready) begin
        m_busy = 0;
      end
    end
  end

  task automatic issue(input bit port, input logic [31:0] addr);
    bit ok = 0;
    @(posedge clk); #1;
    if (port) begin req1_valid = 1; req1_addr = addr; end
    else      begin req0_valid = 1; req0_addr = addr; end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = port ? req1_ready : req0_ready;
    end
    @(posedge clk); #1;
    if (port) req1_valid = 0;
    else      req0_valid = 0;
    check(port ? "accept_p1" : "accept_p0", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 200 && log_q.size() < n; i++) @(posedge clk);
    check("rsp_count", 32'(log_q.size()), 32'(n));
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    bit ok;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i);
    mem[16] = 8'hDE; mem[17] = 8'hAD; mem[18] = 8'hBE; mem[19] = 8'hEF;
    rst_n = 0;
    req0_valid = 0; req0_addr = '0; rsp0_ready = 1;
    req1_valid = 0; req1_addr = '0; rsp1_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_mem_req",    32'(mem_req),    32'd0);
    check("rst_mem_addr",   32'(mem_addr),   32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp0_data",  rsp0_data,       32'd0);
    check("rst_rsp1_err",   32'(rsp1_err),   32'd0);
    @(posedge clk); #1 rst_n = 1;

    // Single fetch
    maddr_q.delete(); log_q.delete();
    issue(0, 32'h10);
    wait_rsp(1);
    if (log_q.size() >= 1) begin
      check("fetch_data",    log_q[0].data, 32'hDEADBEEF);
      check("fetch_err",     32'(log_q[0].err), 32'd0);
      check("fetch_owner",   32'(log_q[0].owner), 32'd0);
      check("fetch_latency", 32'(log_q[0].vld - log_q[0].acc), 32'd5);
    end
    check("fetch_nbeats", 32'(maddr_q.size()), 32'd4);
    if (maddr_q.size() == 4)
      for (int i = 0; i < 4; i++) check("fetch_addr", 32'(maddr_q[i]), 32'(16 + i));

    // Contention from reset
    @(posedge clk); #1;
    rst_n = 0;
    req0_valid = 1; req0_addr = 32'h00;
    req1_valid = 1; req1_addr = 32'h04;
    @(posedge clk); #1;
    rst_n = 1;
    log_q.delete();
    wait_rsp(4);
    #1; req0_valid = 0; req1_valid = 0;
    if (log_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("cont_owner", 32'(log_q[i].owner), 32'(i % 2));
        check("cont_data",  log_q[i].data, (i % 2 == 0) ? 32'h00010203 : 32'h04050607);
      end
      check("cont_throughput", 32'(log_q[1].acc - log_q[0].hs), 32'd1);
    end

    // Backpressure on port 1 with port 0 pending
    log_q.delete();
    rsp1_ready = 0;
    issue(1, 32'h10);
    req0_valid = 1; req0_addr = 32'h04;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = rsp1_valid;
    end
    check("bp_rsp1_seen", 32'(ok), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
      check("bp_rsp1_data",  rsp1_data, 32'hDEADBEEF);
      check("bp_req0_ready", 32'(req0_ready), 32'd0);
    end
    @(posedge clk); #1 rsp1_ready = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req0_ready;
    end
    @(posedge clk); #1 req0_valid = 0;
    wait_rsp(2);
    if (log_q.size() >= 2) begin
      check("bp_owner0",  32'(log_q[0].owner), 32'd1);
      check("bp_gap",     32'(log_q[1].acc - log_q[0].hs), 32'd1);
      check("bp_owner1",  32'(log_q[1].owner), 32'd0);
      check("bp_data1",   log_q[1].data, 32'h04050607);
    end

    // Wrap-around
    mem[126] = 8'h11; mem[127] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
    log_q.delete(); maddr_q.delete();
    issue(0, 32'h7E);
    wait_rsp(1);
    if (log_q.size() >= 1) check("wrap_data", log_q[0].data, 32'h11223344);
    check("wrap_nbeats", 32'(maddr_q.size()), 32'd4);
    if (maddr_q.size() == 4) begin
      check("wrap_addr0", 32'(maddr_q[0]), 32'h7E);
      check("wrap_addr1", 32'(maddr_q[1]), 32'h7F);
      check("wrap_addr2", 32'(maddr_q[2]), 32'h00);
      check("wrap_addr3", 32'(maddr_q[3]), 32'h01);
    end

    // Out of range
    log_q.delete(); maddr_q.delete();
    issue(0, 32'h80);
    wait_rsp(1);
    if (log_q.size() >= 1) begin
      check("oor_data",    log_q[0].data, 32'd0);
      check("oor_err",     32'(log_q[0].err), 32'd1);
      check("oor_latency", 32'(log_q[0].vld - log_q[0].acc), 32'd1);
    end
    check("oor_no_mem", 32'(maddr_q.size()), 32'd0);

    // Reset during beat 2
    log_q.delete(); maddr_q.delete();
    issue(0, 32'h10);
    for (int i = 0; i < 20 && mem_addr != 7'h12; i++) begin
      @(posedge clk); #1;
    end
    check("mid_beat2_addr", 32'(mem_addr), 32'h12);
    rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("mid_mem_req",    32'(mem_req),    32'd0);
    check("mid_mem_addr",   32'(mem_addr),   32'd0);
    check("mid_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("mid_rsp0_data",  rsp0_data,       32'd0);
    check("mid_req0_ready", 32'(req0_ready), 32'd0);
    repeat (10) @(posedge clk);
    check("mid_no_rsp", 32'(log_q.size()), 32'd0);
    issue(0, 32'h10);
    wait_rsp(1);
    if (log_q.size() >= 1) check("mid_refetch", log_q[0].data, 32'hDEADBEEF);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
